// File: rtl/e_mdu_issue_pkg.sv
// Shared MDU definitions: opcode encoding, default latencies and small
// opcode helpers used by the issue stage and the MDU itself.
package e_mdu_issue_pkg;

  localparam int MDU_OP_W     = 5;
  localparam int MDU_MULT_CYC = 5;
  localparam int MDU_DIV_CYC  = 10;
  // Wide enough to hold the longest (divide) latency.
  localparam int MDU_CNT_W    = 4;

  typedef enum logic [MDU_OP_W-1:0] {
    MDU_NONE  = 5'd0,
    MDU_MULT  = 5'd1,
    MDU_MULTU = 5'd2,
    MDU_DIV   = 5'd3,
    MDU_DIVU  = 5'd4,
    MDU_MFHI  = 5'd5,
    MDU_MFLO  = 5'd6,
    MDU_MTHI  = 5'd7,
    MDU_MTLO  = 5'd8
  } mdu_op_e;

  // Encodings outside the defined set behave exactly like "no MDU op".
  function automatic logic [MDU_OP_W-1:0] norm_op(input logic [MDU_OP_W-1:0] op);
    return (op > MDU_MTLO) ? MDU_NONE : op;
  endfunction

  // Ops that occupy the MDU and therefore need a start pulse.
  function automatic logic is_start_op(input logic [MDU_OP_W-1:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) ||
           (op == MDU_DIV)  || (op == MDU_DIVU);
  endfunction

  function automatic logic is_div_op(input logic [MDU_OP_W-1:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/e_mdu_issue_if.sv
// Signal bundle between the D/E pipeline control, E_MDU and the MDU issue
// stage. The slave side is the issue stage; the master side is its environment.
interface e_mdu_issue_if #(
  parameter int OP_W = 5
);

  logic            Req;
  logic [OP_W-1:0] D_MDUOp;
  logic            Stall_other;
  logic            Busy;
  logic [OP_W-1:0] E_MDUOp;
  logic            E_Start;
  logic            Stall_MD;
  logic            Sync_err;

  modport master (
    output Req, D_MDUOp, Stall_other, Busy,
    input  E_MDUOp, E_Start, Stall_MD, Sync_err
  );

  modport slave (
    input  Req, D_MDUOp, Stall_other, Busy,
    output E_MDUOp, E_Start, Stall_MD, Sync_err
  );

endinterface

// File: rtl/e_mdu_issue_mdu_lat_ctr.sv
// Mirror of the MDU latency counter. It is non-zero exactly while E_MDU
// should report Busy, so hazard logic never needs a path from Busy itself.
// Any disagreement with the real Busy is latched into a sticky error flag.
module mdu_lat_ctr #(
  parameter int CNT_W    = 4,
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic is_div,
  input  logic req,
  input  logic busy,
  output logic zero,
  output logic sync_err
);

  logic [CNT_W-1:0] cnt;

  assign zero = (cnt == '0);

  // Load on start, freeze under Req like E_MDU does, otherwise count down to zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= is_div ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
    end else if (req) begin
      cnt <= cnt;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // Sticky divergence flag between the mirror and the real Busy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_err <= 1'b0;
    end else if ((!zero) != busy) begin
      sync_err <= 1'b1;
    end
  end

endmodule

// File: rtl/e_mdu_issue.sv
// D->E issue and hazard stage for the multiply/divide unit. Holds the E-stage
// MDU opcode, produces the start pulse and stalls D-stage md-class ops while
// the MDU is occupied, using a mirror counter instead of E_MDU's Busy.
module e_mdu_issue
  import e_mdu_issue_pkg::*;
#(
  parameter int OP_W     = MDU_OP_W,
  parameter int MULT_CYC = MDU_MULT_CYC,
  parameter int DIV_CYC  = MDU_DIV_CYC
) (
  input logic         clk,
  input logic         reset,
  e_mdu_issue_if.slave mdu
);

  logic [OP_W-1:0] e_op;
  logic [OP_W-1:0] d_op;
  logic            cnt_zero;
  logic            e_start;
  logic            md_busy;
  logic            stall_md;
  logic            sync_err;

  assign d_op     = norm_op(mdu.D_MDUOp);
  assign e_start  = is_start_op(e_op) && !mdu.Req && cnt_zero;
  // An op issuing this cycle occupies the MDU just as much as a running one.
  assign md_busy  = !cnt_zero || e_start;
  assign stall_md = (d_op != MDU_NONE) && md_busy;

  // E-stage opcode register: flush on Req, bubble on any stall, else advance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_op <= MDU_NONE;
    end else if (mdu.Req) begin
      e_op <= MDU_NONE;
    end else if (stall_md || mdu.Stall_other) begin
      e_op <= MDU_NONE;
    end else begin
      e_op <= d_op;
    end
  end

  mdu_lat_ctr #(
    .CNT_W    (MDU_CNT_W),
    .MULT_CYC (MULT_CYC),
    .DIV_CYC  (DIV_CYC)
  ) u_lat_ctr (
    .clk      (clk),
    .reset    (reset),
    .start    (e_start),
    .is_div   (is_div_op(e_op)),
    .req      (mdu.Req),
    .busy     (mdu.Busy),
    .zero     (cnt_zero),
    .sync_err (sync_err)
  );

  assign mdu.E_MDUOp  = e_op;
  assign mdu.E_Start  = e_start;
  assign mdu.Stall_MD = stall_md;
  assign mdu.Sync_err = sync_err;

endmodule

// File: tb/tb_e_mdu_issue.sv
// Bench for e_mdu_issue: directed cycle vectors with hand-computed expected
// outputs pushed to a scoreboard, checked by an independent monitor.
module tb_e_mdu_issue;
  import e_mdu_issue_pkg::*;

  typedef struct {
    logic [4:0] e_op;
    logic       start;
    logic       stall;
    logic       err;
  } vec_t;

  logic clk;
  logic reset;
  vec_t sb[$];
  vec_t exp_v;
  int   checks;
  int   errors;
  logic [4:0] bad_op;

  e_mdu_issue_if #(.OP_W(5)) mdu ();

  e_mdu_issue #(
    .OP_W     (5),
    .MULT_CYC (5),
    .DIV_CYC  (10)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .mdu   (mdu)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  // Drive one cycle's inputs shortly after the rising edge and record what the
  // outputs must look like during that cycle.
  task automatic applyStimulus(input logic rst, input logic req, input logic [4:0] d,
                               input logic so, input logic busy, input logic [4:0] e,
                               input logic st, input logic sm, input logic er);
    vec_t v;
    @(posedge clk);
    #1;
    reset           = rst;
    mdu.Req         = req;
    mdu.D_MDUOp     = d;
    mdu.Stall_other = so;
    mdu.Busy        = busy;
    v.e_op  = e;
    v.start = st;
    v.stall = sm;
    v.err   = er;
    sb.push_back(v);
  endtask

  // Monitor: compares every recorded cycle in the middle of the clock period.
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_v = sb.pop_front();
      checkOutput("E_MDUOp", 32'(mdu.E_MDUOp), 32'(exp_v.e_op));
      checkOutput("E_Start", 32'(mdu.E_Start), 32'(exp_v.start));
      checkOutput("Stall_MD", 32'(mdu.Stall_MD), 32'(exp_v.stall));
      checkOutput("Sync_err", 32'(mdu.Sync_err), 32'(exp_v.err));
    end
  end

  initial begin
    #20000;
    $display("[TB] FAIL watchdog: simulation did not end, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks = 0;
    errors = 0;
    bad_op = 5'd9;
    reset = 1'b0;
    mdu.Req = 1'b0;
    mdu.D_MDUOp = MDU_NONE;
    mdu.Stall_other = 1'b0;
    mdu.Busy = 1'b0;

    // Reset state, including an md op in D that must not stall.
    applyStimulus(0, 0, MDU_NONE, 0, 0, MDU_NONE, 0, 0, 0);
    applyStimulus(0, 0, MDU_MULT, 0, 0, MDU_NONE, 0, 0, 0);
    applyStimulus(1, 0, MDU_NONE, 0, 0, MDU_NONE, 0, 0, 0);

    // mult then mflo: stall for t..t+5, mflo enters E once released.
    applyStimulus(1, 0, MDU_MULT, 0, 0, MDU_NONE, 0, 0, 0);
    applyStimulus(1, 0, MDU_MFLO, 0, 0, MDU_MULT, 1, 1, 0);
    for (int i = 0; i < 5; i++) applyStimulus(1, 0, MDU_MFLO, 0, 1, MDU_NONE, 0, 1, 0);
    applyStimulus(1, 0, MDU_MFLO, 0, 0, MDU_NONE, 0, 0, 0);
    applyStimulus(1, 0, MDU_NONE, 0, 0, MDU_MFLO, 0, 0, 0);
    applyStimulus(1, 0, MDU_NONE, 0, 0, MDU_NONE, 0, 0, 0);

    // div then mthi: 11 stall cycles.
    applyStimulus(1, 0, MDU_DIV, 0, 0, MDU_NONE, 0, 0, 0);
    applyStimulus(1, 0, MDU_MTHI, 0, 0, MDU_DIV, 1, 1, 0);
    for (int i = 0; i < 10; i++) applyStimulus(1, 0, MDU_MTHI, 0, 1, MDU_NONE, 0, 1, 0);
    applyStimulus(1, 0, MDU_MTHI, 0, 0, MDU_NONE, 0, 0, 0);
    applyStimulus(1, 0, MDU_NONE, 0, 0, MDU_MTHI, 0, 0, 0);
    applyStimulus(1, 0, MDU_NONE, 0, 0, MDU_NONE, 0, 0, 0);

    // divu with Req at t+3: counter holds at 8, stall lasts one cycle longer.
    applyStimulus(1, 0, MDU_DIVU, 0, 0, MDU_NONE, 0, 0, 0);
    applyStimulus(1, 0, MDU_MTHI, 0, 0, MDU_DIVU, 1, 1, 0);
    applyStimulus(1, 0, MDU_MTHI, 0, 1, MDU_NONE, 0, 1, 0);
    applyStimulus(1, 0, MDU_MTHI, 0, 1, MDU_NONE, 0, 1, 0);
    applyStimulus(1, 1, MDU_MTHI, 0, 1, MDU_NONE, 0, 1, 0);
    for (int i = 0; i < 8; i++) applyStimulus(1, 0, MDU_MTHI, 0, 1, MDU_NONE, 0, 1, 0);
    applyStimulus(1, 0, MDU_MTHI, 0, 0, MDU_NONE, 0, 0, 0);
    applyStimulus(1, 0, MDU_NONE, 0, 0, MDU_MTHI, 0, 0, 0);
    applyStimulus(1, 0, MDU_NONE, 0, 0, MDU_NONE, 0, 0, 0);

    // Req while mult sits in E: no start, flush, counter stays idle.
    applyStimulus(1, 0, MDU_MULT, 0, 0, MDU_NONE, 0, 0, 0);
    applyStimulus(1, 1, MDU_MFLO, 0, 0, MDU_MULT, 0, 0, 0);
    applyStimulus(1, 0, MDU_MFLO, 0, 0, MDU_NONE, 0, 0, 0);
    applyStimulus(1, 0, MDU_NONE, 0, 0, MDU_MFLO, 0, 0, 0);
    applyStimulus(1, 0, MDU_NONE, 0, 0, MDU_NONE, 0, 0, 0);

    // Asynchronous reset in the cnt=3 cycle of a multu.
    applyStimulus(1, 0, MDU_MULTU, 0, 0, MDU_NONE, 0, 0, 0);
    applyStimulus(1, 0, MDU_MFLO, 0, 0, MDU_MULTU, 1, 1, 0);
    applyStimulus(1, 0, MDU_MFLO, 0, 1, MDU_NONE, 0, 1, 0);
    applyStimulus(1, 0, MDU_MFLO, 0, 1, MDU_NONE, 0, 1, 0);
    applyStimulus(0, 0, MDU_MFLO, 0, 0, MDU_NONE, 0, 0, 0);
    applyStimulus(0, 0, MDU_MFLO, 0, 0, MDU_NONE, 0, 0, 0);
    applyStimulus(1, 0, MDU_MFLO, 0, 0, MDU_NONE, 0, 0, 0);
    applyStimulus(1, 0, MDU_NONE, 0, 0, MDU_MFLO, 0, 0, 0);
    applyStimulus(1, 0, MDU_NONE, 0, 0, MDU_NONE, 0, 0, 0);

    // Busy dropped early at cnt=2: sticky error until reset.
    applyStimulus(1, 0, MDU_MULT, 0, 0, MDU_NONE, 0, 0, 0);
    applyStimulus(1, 0, MDU_NONE, 0, 0, MDU_MULT, 1, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, MDU_NONE, 0, 1, MDU_NONE, 0, 0, 0);
    applyStimulus(1, 0, MDU_NONE, 0, 0, MDU_NONE, 0, 0, 0);
    applyStimulus(1, 0, MDU_NONE, 0, 1, MDU_NONE, 0, 0, 1);
    applyStimulus(1, 0, MDU_NONE, 0, 0, MDU_NONE, 0, 0, 1);
    applyStimulus(1, 0, MDU_NONE, 0, 0, MDU_NONE, 0, 0, 1);
    applyStimulus(0, 0, MDU_NONE, 0, 0, MDU_NONE, 0, 0, 0);
    applyStimulus(1, 0, MDU_NONE, 0, 0, MDU_NONE, 0, 0, 0);

    // Undefined opcode acts as none; mt ops pass without start; other-stall bubbles.
    applyStimulus(1, 0, bad_op, 0, 0, MDU_NONE, 0, 0, 0);
    applyStimulus(1, 0, MDU_MTLO, 0, 0, MDU_NONE, 0, 0, 0);
    applyStimulus(1, 0, MDU_MULT, 1, 0, MDU_MTLO, 0, 0, 0);
    applyStimulus(1, 0, MDU_MFHI, 0, 0, MDU_NONE, 0, 0, 0);
    applyStimulus(1, 0, MDU_NONE, 0, 0, MDU_MFHI, 0, 0, 0);
    applyStimulus(1, 0, MDU_NONE, 0, 0, MDU_NONE, 0, 0, 0);

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: got %0d pending, expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
